exchange_responder: RTL

EXCHANGE_RESPONDER -- requirements
Module: exchange_responder

---
 rtl/exchange_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/exchange_responder.sv
// exchange_responder: queues orders and answers each with execution reports after a fixed latency.
//   clk, rst                  clock, async active-high reset
//   ord_valid/ord_ready       order handshake; ord_id/ord_symbol/ord_price/ord_volume/ord_type order fields
//   exec_valid/exec_ready     report handshake; exec_id/exec_price/exec_volume/exec_status report fields
//   fifo_count                orders waiting in the queue
//   fill_count                FILLED reports handshaken (wraps)
module exchange_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int ACK_LATENCY = 4,
   parameter int MAX_FILL    = 100
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ord_valid,
   output logic                          ord_ready,
   input  logic [DATA_WIDTH-1:0]         ord_id,
   input  logic [DATA_WIDTH-1:0]         ord_symbol,
   input  logic [DATA_WIDTH-1:0]         ord_price,
   input  logic [DATA_WIDTH-1:0]         ord_volume,
   input  logic [7:0]                    ord_type,
   output logic                          exec_valid,
   input  logic                          exec_ready,
   output logic [DATA_WIDTH-1:0]         exec_id,
   output logic [DATA_WIDTH-1:0]         exec_price,
   output logic [DATA_WIDTH-1:0]         exec_volume,
   output logic [7:0]                    exec_status,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [31:0]                   fill_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 3*DATA_WIDTH + 8;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] MF = DATA_WIDTH'(MAX_FILL);
   typedef enum logic [1:0] {IDLE, WAIT, REPORT} state_t;
   state_t st_q;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q, cnt_d;
   logic [31:0] lat_q;
   logic [DATA_WIDTH-1:0] id_q, price_q, rem_q;
   logic rej_q, can_q;
   logic push, pop, fill_ok;
   logic [EW-1:0] head;
   logic [7:0] h_type;
   logic [DATA_WIDTH-1:0] h_id, h_price, h_vol;
   logic unused_sym;
   assign unused_sym = ^ord_symbol;
   assign ord_ready  = cnt_q != FULL;
   assign fifo_count = cnt_q;
   assign push = ord_valid && ord_ready;
   // pop only from IDLE or on the closing handshake of a finished order
   assign pop = (cnt_q != '0) &&
                (st_q == IDLE || (st_q == REPORT && exec_ready && exec_status != 8'h02));
   assign head    = mem_q[rd_q];
   assign h_type  = head[7:0];
   assign h_vol   = head[DATA_WIDTH+7:8];
   assign h_price = head[2*DATA_WIDTH+7:DATA_WIDTH+8];
   assign h_id    = head[3*DATA_WIDTH+7:2*DATA_WIDTH+8];
   assign fill_ok = (h_type == 8'h01 || h_type == 8'h02) && h_vol != '0 && h_price != '0;
   always_comb cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   always_ff @(posedge clk) if (push) mem_q[wr_q] <= {ord_id, ord_price, ord_volume, ord_type};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push);
         rd_q  <= rd_q + AW'(pop);
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= IDLE;
         lat_q       <= '0;
         id_q        <= '0;
         price_q     <= '0;
         rem_q       <= '0;
         rej_q       <= 1'b0;
         can_q       <= 1'b0;
         exec_valid  <= 1'b0;
         exec_id     <= '0;
         exec_price  <= '0;
         exec_volume <= '0;
         exec_status <= '0;
         fill_count  <= '0;
      end else begin
         case (st_q)
            WAIT:
               if (lat_q == 32'd1) begin
                  st_q        <= REPORT;
                  exec_valid  <= 1'b1;
                  exec_id     <= id_q;
                  exec_price  <= price_q;
                  exec_status <= rej_q ? 8'h04 : can_q ? 8'h03 : (rem_q <= MF) ? 8'h01 : 8'h02;
                  exec_volume <= (rej_q || can_q) ? '0 : (rem_q <= MF) ? rem_q : MF;
                  if (!rej_q && !can_q && rem_q > MF) rem_q <= rem_q - MF;
               end else lat_q <= lat_q - 32'd1;
            REPORT:
               if (exec_ready) begin
                  exec_valid <= 1'b0;
                  if (exec_status == 8'h02) begin
                     lat_q <= 32'(ACK_LATENCY);
                     st_q  <= WAIT;
                  end else begin
                     st_q <= IDLE;
                     if (exec_status == 8'h01) fill_count <= fill_count + 32'd1;
                  end
               end
            default: ;
         endcase
         // a pop always starts a fresh order, overriding the state chosen above
         if (pop) begin
            st_q    <= WAIT;
            lat_q   <= 32'(ACK_LATENCY);
            id_q    <= h_id;
            price_q <= h_price;
            rem_q   <= h_vol;
            can_q   <= h_type == 8'h03;
            rej_q   <= h_type != 8'h03 && !fill_ok;
         end
      end
   end
endmodule
